// File: rtl/ex_div.sv
// rtl/ex_div.sv - iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
// Holds the pipeline via stallreq_o until the result pulses out on ready_o.
module ex_div #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [XLEN-1:0]  dividend_i,
   input  logic [XLEN-1:0]  divisor_i,
   input  logic             flush_i,
   output logic [XLEN-1:0]  result_o,
   output logic             ready_o,
   output logic             busy_o,
   output logic             stallreq_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  quo_r;
   logic [XLEN-1:0]  rem_r;
   logic [XLEN-1:0]  dsr_r;
   logic             is_rem_r;
   logic             neg_q_r;
   logic             neg_r_r;

   logic             signed_op;
   logic             a_neg;
   logic             b_neg;
   logic [XLEN-1:0]  a_abs;
   logic [XLEN-1:0]  b_abs;
   logic             div_zero;
   logic             ovf;

   logic [XLEN:0]    trial;
   logic [XLEN:0]    diff;
   logic             ge;
   logic [XLEN-1:0]  quo_nxt;
   logic [XLEN-1:0]  rem_nxt;
   logic [XLEN-1:0]  quo_fix;
   logic [XLEN-1:0]  rem_fix;

   assign signed_op = ~op_i[0];
   assign a_neg     = signed_op & dividend_i[XLEN-1];
   assign b_neg     = signed_op & divisor_i[XLEN-1];
   assign a_abs     = a_neg ? -dividend_i : dividend_i;
   assign b_abs     = b_neg ? -divisor_i : divisor_i;
   assign div_zero  = (divisor_i == '0);
   assign ovf       = signed_op && (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) && (divisor_i == '1);

   // One restoring step: the partial remainder stays below the divisor, so XLEN+1 bits suffice.
   assign trial   = {rem_r, quo_r[XLEN-1]};
   assign diff    = trial - {1'b0, dsr_r};
   assign ge      = ~diff[XLEN];
   assign rem_nxt = ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
   assign quo_nxt = {quo_r[XLEN-2:0], ge};
   assign quo_fix = neg_q_r ? -quo_nxt : quo_nxt;
   assign rem_fix = neg_r_r ? -rem_nxt : rem_nxt;

   assign ready_o    = (state == S_DONE);
   assign busy_o     = (state != S_IDLE);
   assign stallreq_o = rst_n & start_i & ~ready_o & ~flush_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         quo_r    <= '0;
         rem_r    <= '0;
         dsr_r    <= '0;
         is_rem_r <= 1'b0;
         neg_q_r  <= 1'b0;
         neg_r_r  <= 1'b0;
         result_o <= '0;
      end else if (flush_i) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  is_rem_r <= op_i[1];
                  if (div_zero) begin
                     result_o <= op_i[1] ? dividend_i : '1;
                     state    <= S_DONE;
                  end else if (ovf) begin
                     result_o <= op_i[1] ? '0 : dividend_i;
                     state    <= S_DONE;
                  end else begin
                     quo_r   <= a_abs;
                     rem_r   <= '0;
                     dsr_r   <= b_abs;
                     neg_q_r <= a_neg ^ b_neg;
                     neg_r_r <= a_neg;
                     cnt     <= CNT_W'(XLEN);
                     state   <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               quo_r <= quo_nxt;
               rem_r <= rem_nxt;
               cnt   <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  result_o <= is_rem_r ? rem_fix : quo_fix;
                  state    <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - self-checking bench for ex_div
// Directed corner cases plus a random sweep against an arithmetic reference model.
module tb_ex_div;

   logic        clk;
   logic        rst_n;
   logic        start_i;
   logic [1:0]  op_i;
   logic [31:0] dividend_i;
   logic [31:0] divisor_i;
   logic        flush_i;
   logic [31:0] result_o;
   logic        ready_o;
   logic        busy_o;
   logic        stallreq_o;

   int checks;
   int errors;

   ex_div #(.XLEN(32), .CNT_W(6)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start_i),
      .op_i       (op_i),
      .dividend_i (dividend_i),
      .divisor_i  (divisor_i),
      .flush_i    (flush_i),
      .result_o   (result_o),
      .ready_o    (ready_o),
      .busy_o     (busy_o),
      .stallreq_o (stallreq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q;
      logic [31:0] r;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (op[0] == 1'b0) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
         end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
         end
      end else begin
         q = a / b;
         r = a % b;
      end
      return op[1] ? r : q;
   endfunction

   function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return 1;
      if (op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Driver only: issue one op just after a rising edge and report what came back.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output int stalls);
      lat    = -1;
      res    = 'x;
      stalls = 0;
      start_i    = 1'b1;
      op_i       = op;
      dividend_i = a;
      divisor_i  = b;
      for (int k = 0; k < 45; k++) begin
         @(negedge clk);
         if (stallreq_o) stalls++;
         if (ready_o) begin
            lat = k;
            res = result_o;
            break;
         end
         if (k == 3) begin
            dividend_i = $urandom;
            divisor_i  = $urandom;
            op_i       = 2'($urandom);
         end
      end
      @(posedge clk);
      #1;
      start_i = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start_i = 1'b1;
      #2;
      checks++;
      if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 32'd0 || stallreq_o !== 1'b0) begin
         errors++;
         $display("FAIL reset busy=%b ready=%b result=%h stall=%b required 0/0/0/0",
                  busy_o, ready_o, result_o, stallreq_o);
      end
      start_i = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_directed;
      logic [1:0]  ops [8];
      logic [31:0] as  [8];
      logic [31:0] bs  [8];
      logic [31:0] exp_res [8];
      int          exp_lat [8];
      int lat;
      int stalls;
      logic [31:0] res;
      ops = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10};
      as  = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      bs  = '{32'd7, 32'd2, 32'd2, 32'd16, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      exp_res = '{32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd15, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
      exp_lat = '{33, 33, 33, 33, 1, 1, 1, 1};
      for (int i = 0; i < 8; i++) begin
         run_op(ops[i], as[i], bs[i], lat, res, stalls);
         checks++;
         if (res !== exp_res[i]) begin
            errors++;
            $display("FAIL directed%0d_result got %h required %h", i, res, exp_res[i]);
         end
         checks++;
         if (lat != exp_lat[i]) begin
            errors++;
            $display("FAIL directed%0d_latency got %0d required %0d", i, lat, exp_lat[i]);
         end
         checks++;
         if (stalls != exp_lat[i]) begin
            errors++;
            $display("FAIL directed%0d_stall_cycles got %0d required %0d", i, stalls, exp_lat[i]);
         end
      end
   endtask

   task automatic test_flush;
      int lat;
      int stalls;
      int pulses;
      logic [31:0] res;
      start_i    = 1'b1;
      op_i       = 2'b01;
      dividend_i = 32'd1000;
      divisor_i  = 32'd3;
      repeat (10) @(posedge clk);
      #1;
      flush_i = 1'b1;
      start_i = 1'b0;
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_busy got %b required 0", busy_o);
      end
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (ready_o) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL flush_no_ready got %0d pulses required 0", pulses);
      end
      @(posedge clk);
      #1;
      run_op(2'b01, 32'd9, 32'd3, lat, res, stalls);
      checks++;
      if (res !== 32'd3 || lat != 33) begin
         errors++;
         $display("FAIL after_flush got %h lat %0d required 00000003 lat 33", res, lat);
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      int stalls;
      logic [31:0] res;
      run_op(2'b00, 32'd50, 32'd0, lat, res, stalls);
      run_op(2'b11, 32'd50, 32'd7, lat, res, stalls);
      checks++;
      if (res !== 32'd1 || lat != 33) begin
         errors++;
         $display("FAIL back_to_back got %h lat %0d required 00000001 lat 33", res, lat);
      end
   endtask

   task automatic test_reset_mid_calc;
      start_i    = 1'b1;
      op_i       = 2'b01;
      dividend_i = 32'd12345;
      divisor_i  = 32'd11;
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid_calc busy=%b ready=%b result=%h required 0/0/0", busy_o, ready_o, result_o);
      end
      start_i = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_random;
      int lat;
      int stalls;
      logic [31:0] res;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom);
         a  = $urandom;
         case ($urandom_range(0, 4))
            0:       b = 32'($urandom_range(0, 15));
            1:       b = -32'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         if (i == 5) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         run_op(op, a, b, lat, res, stalls);
         checks++;
         if (res !== ref_div(op, a, b) || lat != ref_lat(op, a, b)) begin
            errors++;
            $display("FAIL random%0d op=%0d a=%h b=%h got %h lat %0d required %h lat %0d",
                     i, op, a, b, res, lat, ref_div(op, a, b), ref_lat(op, a, b));
         end
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      rst_n      = 1'b0;
      start_i    = 1'b0;
      op_i       = 2'b00;
      dividend_i = 32'd0;
      divisor_i  = 32'd0;
      flush_i    = 1'b0;
      test_reset();
      test_directed();
      test_flush();
      test_back_to_back();
      test_reset_mid_calc();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
